// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Registers EX results, runs one data-memory access per load/store over a
// req/ack handshake, stalls upstream while an access is outstanding, and
// delivers the regfile write (ALU result or load data) to WB.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> an access without ack for TIMEOUT_CYCLES cycles is aborted
//                and mem_err pulses for one cycle afterwards.
//   undefined -> no timeout counter, mem_err tied low, ACCESS waits for ack.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access outstanding; EX op accepted every cycle
// ACCESS | dmem request outstanding; upstream stalled; EX inputs ignored

`timescale 1ns/1ps

module mem_stage #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_regfile_we,
  input  logic [REG_ADDR_W-1:0] ex_mem_regfile_waddr,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_mem_re,
  input  logic                  ex_mem_we,
  input  logic [ADDR_W-1:0]     ex_mem_mem_addr,
  input  logic [DATA_W-1:0]     ex_mem_store_data,
  input  logic                  mem_flush,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  mem_stall_req,
  output logic                  wb_regfile_we,
  output logic [REG_ADDR_W-1:0] wb_regfile_waddr,
  output logic [DATA_W-1:0]     wb_regfile_wdata,
  output logic                  mem_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Word-align mask: byte-offset bits are dropped when the address is latched.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  state_t state_q, state_d;

  // Access context captured on the IDLE edge that starts an access.
  logic                  is_store_q;
  logic                  acc_rf_we_q;
  logic [REG_ADDR_W-1:0] acc_waddr_q;
  logic [ADDR_W-1:0]     acc_addr_q;
  logic [DATA_W-1:0]     acc_sdata_q;

  logic                  capture;
  logic                  wb_we_d;
  logic [REG_ADDR_W-1:0] wb_waddr_d;
  logic [DATA_W-1:0]     wb_wdata_d;
  logic                  timeout_hit;
  logic                  in_access;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  // Down-counter of remaining no-ack cycles; terminal count is zero.
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_tc;
  logic             mem_err_q;

  assign tmo_tc = (tmo_cnt_q == '0);
`else
  logic             tmo_tc;

  assign tmo_tc = 1'b0;
`endif

  // Next-state and WB/latch control; flush overrides everything else.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    wb_we_d     = 1'b0;
    wb_waddr_d  = wb_regfile_waddr;
    wb_wdata_d  = wb_regfile_wdata;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_mem_re || ex_mem_we) begin
          // Memory op: emit a bubble to WB and start the access.
          capture = 1'b1;
          state_d = ACCESS;
        end else begin
          wb_we_d    = ex_mem_regfile_we;
          wb_waddr_d = ex_mem_regfile_waddr;
          wb_wdata_d = ex_alu_result;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = IDLE;
          if (!is_store_q) begin
            wb_we_d    = acc_rf_we_q;
            wb_waddr_d = acc_waddr_q;
            wb_wdata_d = dmem_rdata;
          end
        end else if (tmo_tc) begin
          // Ack on the limit cycle is handled above as a normal completion.
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_flush) begin
      state_d     = IDLE;
      capture     = 1'b0;
      wb_we_d     = 1'b0;
      wb_waddr_d  = wb_regfile_waddr;
      wb_wdata_d  = wb_regfile_wdata;
      timeout_hit = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Access context latch and registered WB outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q       <= 1'b0;
      acc_rf_we_q      <= 1'b0;
      acc_waddr_q      <= '0;
      acc_addr_q       <= '0;
      acc_sdata_q      <= '0;
      wb_regfile_we    <= 1'b0;
      wb_regfile_waddr <= '0;
      wb_regfile_wdata <= '0;
    end else begin
      if (capture) begin
        // re=we=1 is treated as a store.
        is_store_q  <= ex_mem_we;
        acc_rf_we_q <= ex_mem_regfile_we;
        acc_waddr_q <= ex_mem_regfile_waddr;
        acc_addr_q  <= ex_mem_mem_addr & WORD_MASK;
        acc_sdata_q <= ex_mem_store_data;
      end
      wb_regfile_we    <= wb_we_d;
      wb_regfile_waddr <= wb_waddr_d;
      wb_regfile_wdata <= wb_wdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter: reloaded on access entry, counts down per no-ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (capture) begin
      tmo_cnt_q <= CNT_LOAD;
    end else if (state_q == ACCESS && !dmem_ack && !tmo_tc) begin
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end
  end

  // mem_err is a one-cycle pulse in the cycle after the abort edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= timeout_hit;
    end
  end

  assign mem_err = mem_err_q;
`else
  // Tied low; the parameter is referenced so both builds elaborate cleanly.
  assign mem_err = 1'b0 & (TIMEOUT_CYCLES == 0) & timeout_hit;
`endif

  // Request-side outputs come from the latched context and read 0 in IDLE.
  assign in_access     = (state_q == ACCESS);
  assign dmem_req      = in_access;
  assign mem_stall_req = in_access;
  assign dmem_we       = in_access & is_store_q;
  assign dmem_addr     = in_access ? acc_addr_q  : '0;
  assign dmem_wdata    = in_access ? acc_sdata_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: scripted scenarios plus a random op stream,
// with WB writes checked against a scoreboard queue.

`timescale 1ns/1ps

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_mem_regfile_we;
  logic [4:0]  ex_mem_regfile_waddr;
  logic [31:0] ex_alu_result;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [31:0] ex_mem_mem_addr;
  logic [31:0] ex_mem_store_data;
  logic        mem_flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall_req;
  logic        wb_regfile_we;
  logic [4:0]  wb_regfile_waddr;
  logic [31:0] wb_regfile_wdata;
  logic        mem_err;

  mem_stage #(
    .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_mem_regfile_we(ex_mem_regfile_we),
    .ex_mem_regfile_waddr(ex_mem_regfile_waddr),
    .ex_alu_result(ex_alu_result),
    .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we),
    .ex_mem_mem_addr(ex_mem_mem_addr),
    .ex_mem_store_data(ex_mem_store_data),
    .mem_flush(mem_flush),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .mem_stall_req(mem_stall_req),
    .wb_regfile_we(wb_regfile_we),
    .wb_regfile_waddr(wb_regfile_waddr),
    .wb_regfile_wdata(wb_regfile_wdata),
    .mem_err(mem_err)
  );

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  // Responder configuration for the access currently outstanding.
  int          ack_wait  = -1;
  logic [31:0] cur_rdata = '0;
  logic [31:0] exp_addr  = '0;
  logic        exp_we    = 1'b0;
  logic [31:0] exp_wdata = '0;
  logic        idle_ack  = 1'b0;
  int          req_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_mem_regfile_we    = 1'b0;
    ex_mem_regfile_waddr = '0;
    ex_alu_result        = '0;
    ex_mem_re            = 1'b0;
    ex_mem_we            = 1'b0;
    ex_mem_mem_addr      = '0;
    ex_mem_store_data    = '0;
  endtask

  // Present one EX op, hold it while stalled, and return #1 after the edge
  // that accepts it. Expected WB results are pushed on acceptance.
  task automatic issue_op(input logic re, input logic we, input logic rf_we,
                          input logic [4:0] waddr, input logic [31:0] alu,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int k, input logic [31:0] rdata,
                          input bit will_abort);
    logic stalled;
    int   n;
    ex_mem_re            = re;
    ex_mem_we            = we;
    ex_mem_regfile_we    = rf_we;
    ex_mem_regfile_waddr = waddr;
    ex_alu_result        = alu;
    ex_mem_mem_addr      = addr;
    ex_mem_store_data    = sdata;
    n = 0;
    do begin
      stalled = mem_stall_req;
      @(posedge clk);
      #1;
      n++;
    end while (stalled && n < 100);
    if (stalled) chk("accept_timeout", stalled, 0);
    if (re || we) begin
      exp_addr  = addr & 32'hFFFF_FFFC;
      exp_we    = we;
      exp_wdata = sdata;
      ack_wait  = k;
      cur_rdata = rdata;
    end
    if (!will_abort) begin
      if (!(re || we)) begin
        if (rf_we) sb.push_back({waddr, alu});
      end else if (!we && rf_we) begin
        sb.push_back({waddr, rdata});
      end
    end
    clear_ex();
  endtask

  // Count ACCESS cycles until req drops (bounded).
  task automatic wait_idle(output int len);
    len = 0;
    while (dmem_req && len < 60) begin
      len++;
      @(posedge clk);
      #1;
    end
    chk("idle_reached", dmem_req, 0);
  endtask

  // Memory model: checks request fields every ACCESS cycle, acks after k waits.
  initial begin
    logic hit;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        req_cnt++;
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", dmem_we, exp_we);
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
        hit        = (ack_wait >= 0) && (req_cnt == ack_wait + 1);
        dmem_ack   = hit;
        dmem_rdata = hit ? cur_rdata : $urandom;
      end else begin
        req_cnt    = 0;
        dmem_ack   = idle_ack;
        dmem_rdata = $urandom;
      end
    end
  end

  // WB monitor: every write must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_regfile_we === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", wb_regfile_we, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_waddr", wb_regfile_waddr, mon_e.waddr);
          chk("wb_wdata", wb_regfile_wdata, mon_e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int err_cnt;
    int op;
    logic [31:0] r_addr;

    rst       = 1'b1;
    mem_flush = 1'b0;
    clear_ex();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_we", wb_regfile_we, 0);
    chk("rst_wb_waddr", wb_regfile_waddr, 0);
    chk("rst_wb_wdata", wb_regfile_wdata, 0);
    chk("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: ALU op, with a stray ack in IDLE that must be ignored.
    idle_ack = 1'b1;
    issue_op(0, 0, 1, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("t1_wb_we", wb_regfile_we, 1);
    chk("t1_stall", mem_stall_req, 0);
    chk("t1_req", dmem_req, 0);
    @(posedge clk);
    #1;
    idle_ack = 1'b0;
    chk("t1_bubble_wb_we", wb_regfile_we, 0);

    // 2: load, 3 wait cycles.
    issue_op(1, 0, 1, 5'd9, 32'h0, 32'h0000_0106, 32'h0, 3, 32'hDEAD_BEEF, 0);
    chk("t2_dmem_addr", dmem_addr, 32'h0000_0104);
    chk("t2_stall", mem_stall_req, 1);
    chk("t2_wb_bubble", wb_regfile_we, 0);
    wait_idle(len);
    chk("t2_req_len", len, 4);
    chk("t2_wb_we", wb_regfile_we, 1);
    chk("t2_wb_wdata", wb_regfile_wdata, 32'hDEAD_BEEF);

    // 3: store acked in the first cycle, back-to-back ALU op.
    issue_op(0, 1, 1, 5'd2, 32'h0, 32'h0000_0020, 32'hA5A5_A5A5, 0, 32'h0, 0);
    chk("t3_dmem_we", dmem_we, 1);
    chk("t3_dmem_wdata", dmem_wdata, 32'hA5A5_A5A5);
    issue_op(0, 0, 1, 5'd3, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 32'h0, 0);
    chk("t3_alu_wb_we", wb_regfile_we, 1);

    // re=we=1 behaves as a store: no WB write.
    issue_op(1, 1, 1, 5'd4, 32'h0, 32'h0000_0033, 32'h5555_AAAA, 1, 32'h1111_1111, 0);
    chk("both_dmem_we", dmem_we, 1);
    wait_idle(len);
    chk("both_req_len", len, 2);

    // 4: flush coincident with ack during a load; EX op in that cycle dropped.
    issue_op(1, 0, 1, 5'd10, 32'h0, 32'h0000_0044, 32'h0, 2, 32'hCAFE_0001, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    mem_flush            = 1'b1;
    ex_mem_regfile_we    = 1'b1;
    ex_mem_regfile_waddr = 5'd7;
    ex_alu_result        = 32'h7777_7777;
    @(posedge clk);
    #1;
    mem_flush = 1'b0;
    clear_ex();
    chk("t4_req", dmem_req, 0);
    chk("t4_stall", mem_stall_req, 0);
    chk("t4_wb_we", wb_regfile_we, 0);
    @(posedge clk);
    #1;
    chk("t4_wb_we_next", wb_regfile_we, 0);

    // 5: reset mid-ACCESS, then a fresh load.
    issue_op(1, 0, 1, 5'd11, 32'h0, 32'h0000_0200, 32'h0, -1, 32'h0, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_req", dmem_req, 0);
    chk("t5_stall", mem_stall_req, 0);
    chk("t5_dmem_we", dmem_we, 0);
    chk("t5_dmem_addr", dmem_addr, 0);
    chk("t5_wb_we", wb_regfile_we, 0);
    chk("t5_wb_waddr", wb_regfile_waddr, 0);
    chk("t5_wb_wdata", wb_regfile_wdata, 0);
    chk("t5_mem_err", mem_err, 0);
    issue_op(1, 0, 1, 5'd12, 32'h0, 32'h0000_1008, 32'h0, 1, 32'h0F0F_3C3C, 0);
    wait_idle(len);
    chk("t5_req_len", len, 2);

    // 6: no ack at all.
    issue_op(1, 0, 1, 5'd13, 32'h0, 32'h0000_0300, 32'h0, -1, 32'h0, 1);
`ifdef MEM_TIMEOUT_EN
    wait_idle(len);
    chk("t6_timeout_len", len, 16);
    chk("t6_mem_err", mem_err, 1);
    chk("t6_wb_we", wb_regfile_we, 0);
    @(posedge clk);
    #1;
    chk("t6_mem_err_pulse", mem_err, 0);
`else
    err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_err) err_cnt++;
      @(posedge clk);
      #1;
    end
    chk("t6_req_held", dmem_req, 1);
    chk("t6_mem_err_cnt", err_cnt, 0);
    mem_flush = 1'b1;
    @(posedge clk);
    #1;
    mem_flush = 1'b0;
    chk("t6_flush_req", dmem_req, 0);
`endif

    // Random mixed stream, back-to-back, random ack latency.
    for (int i = 0; i < 40; i++) begin
      op     = $urandom_range(0, 3);
      r_addr = $urandom;
      issue_op(op == 1 || op == 3, op == 2 || op == 3, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom, r_addr, $urandom,
               $urandom_range(0, 3), $urandom, 0);
    end
    wait_idle(len);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
